// File: rtl/up_down_counter_p_if.sv
// Control/status bundle for the up/down counter.
// The master drives the controls and the slave returns the count and flags.
interface up_down_counter_p_if #(
   parameter int WIDTH = 4
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             up;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             sat;

   modport master (
      output clr, load, load_val, en, up,
      input  count, tc, wrap, sat
   );

   modport slave (
      input  clr, load, load_val, en, up,
      output count, tc, wrap, sat
   );
endinterface

// File: rtl/up_down_counter_p.sv
// Modulo-MODULUS up/down counter with clear, clamped load,
// terminal count, wrap pulse and optional saturation at the range ends.
module up_down_counter_p #(
   parameter int     WIDTH    = 4,
   parameter longint MODULUS  = 16,
   parameter bit     SATURATE = 1'b0
) (
   input  logic                clk,
   input  logic                reset_n,
   up_down_counter_p_if.slave  bus
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             sat_q;
   logic             sat_d;
   logic             at_top;
   logic             at_bot;
   logic             at_end;

   assign at_top = (count_q == MAX);
   assign at_bot = (count_q == '0);
   assign at_end = (bus.up & at_top) | (~bus.up & at_bot);

   assign bus.tc    = bus.en & at_end;
   assign bus.count = count_q;
   assign bus.wrap  = wrap_q;
   assign bus.sat   = sat_q;

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      sat_d   = sat_q;
      if (bus.clr) begin
         count_d = '0;
         sat_d   = 1'b0;
      end else if (bus.load) begin
         count_d = (bus.load_val > MAX) ? MAX : bus.load_val;
         sat_d   = 1'b0;
      end else if (bus.en) begin
         if (at_end) begin
            if (SATURATE) begin
               // Pulse wrap only on the first holding cycle.
               wrap_d = ~sat_q;
               sat_d  = 1'b1;
            end else begin
               count_d = bus.up ? '0 : MAX;
               wrap_d  = 1'b1;
               sat_d   = 1'b0;
            end
         end else begin
            count_d = bus.up ? count_q + 1'b1 : count_q - 1'b1;
            sat_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
      end
   end

endmodule

// File: tb/tb_up_down_counter_p.sv
// Directed bench for up_down_counter_p: wrapping, saturating
// and full-binary-range instances driven through one linear sequence.
module tb_up_down_counter_p;

   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   up_down_counter_p_if #(.WIDTH(4)) ia ();
   up_down_counter_p_if #(.WIDTH(4)) ib ();
   up_down_counter_p_if #(.WIDTH(4)) ic ();

   up_down_counter_p #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ia)
   );

   up_down_counter_p #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ib)
   );

   up_down_counter_p #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_c (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ic)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset_n = 1'b0;
      ia.clr = 0; ia.load = 0; ia.load_val = '0; ia.en = 0; ia.up = 0;
      ib.clr = 0; ib.load = 0; ib.load_val = '0; ib.en = 0; ib.up = 0;
      ic.clr = 0; ic.load = 0; ic.load_val = '0; ic.en = 0; ic.up = 0;
      #12;
      chk("rst_a_count", 32'(ia.count), 0);
      chk("rst_a_wrap", 32'(ia.wrap), 0);
      chk("rst_b_sat", 32'(ib.sat), 0);
      ia.en = 1; ia.up = 0;
      #1;
      chk("rst_tc_down", 32'(ia.tc), 1);
      ia.up = 1;
      #1;
      chk("rst_tc_up", 32'(ia.tc), 0);
      reset_n = 1'b1;

      // Count up through the wrap 9 -> 0.
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk("a_up_count", 32'(ia.count), i % 10);
         chk("a_up_wrap", 32'(ia.wrap), (i == 10) ? 1 : 0);
         chk("a_up_tc", 32'(ia.tc), (i % 10 == 9) ? 1 : 0);
      end

      ia.clr = 1;
      tick();
      chk("a_clr_count", 32'(ia.count), 0);
      chk("a_clr_wrap", 32'(ia.wrap), 0);
      ia.clr = 0; ia.up = 0;
      #1;
      chk("a_dn_tc0", 32'(ia.tc), 1);
      tick();
      chk("a_dn_count9", 32'(ia.count), 9);
      chk("a_dn_wrap9", 32'(ia.wrap), 1);
      tick();
      chk("a_dn_count8", 32'(ia.count), 8);
      chk("a_dn_wrap8", 32'(ia.wrap), 0);
      tick();
      chk("a_dn_count7", 32'(ia.count), 7);

      ia.en = 0; ia.load = 1; ia.load_val = 4'd13;
      tick();
      chk("a_load_clamp", 32'(ia.count), 9);
      chk("a_load_tc_off", 32'(ia.tc), 0);
      ia.clr = 1; ia.en = 1; ia.up = 1;
      tick();
      chk("a_clr_prio", 32'(ia.count), 0);
      ia.clr = 0; ia.load_val = 4'd6;
      tick();
      chk("a_load_prio", 32'(ia.count), 6);
      ia.load = 0; ia.en = 0;
      tick();
      chk("a_hold", 32'(ia.count), 6);

      // Saturating instance: hold at 9, then move off.
      ib.load = 1; ib.load_val = 4'd8;
      tick();
      chk("b_load8", 32'(ib.count), 8);
      ib.load = 0; ib.en = 1; ib.up = 1;
      tick();
      chk("b_cnt_a", 32'(ib.count), 9);
      chk("b_wrap_a", 32'(ib.wrap), 0);
      chk("b_sat_a", 32'(ib.sat), 0);
      chk("b_tc_a", 32'(ib.tc), 1);
      tick();
      chk("b_cnt_b", 32'(ib.count), 9);
      chk("b_wrap_b", 32'(ib.wrap), 1);
      chk("b_sat_b", 32'(ib.sat), 1);
      tick();
      chk("b_cnt_c", 32'(ib.count), 9);
      chk("b_wrap_c", 32'(ib.wrap), 0);
      chk("b_sat_c", 32'(ib.sat), 1);
      ib.up = 0;
      tick();
      chk("b_dn_count", 32'(ib.count), 8);
      chk("b_dn_sat", 32'(ib.sat), 0);
      ib.load = 1; ib.load_val = 4'd0;
      tick();
      ib.load = 0;
      tick();
      chk("b_bot_count", 32'(ib.count), 0);
      chk("b_bot_wrap", 32'(ib.wrap), 1);
      chk("b_bot_sat", 32'(ib.sat), 1);

      // Full binary range: overflow/underflow with up toggling.
      ic.load = 1; ic.load_val = 4'd15;
      tick();
      chk("c_load15", 32'(ic.count), 15);
      ic.load = 0; ic.en = 1; ic.up = 1;
      tick();
      chk("c_ovf_count", 32'(ic.count), 0);
      chk("c_ovf_wrap", 32'(ic.wrap), 1);
      for (int i = 0; i < 4; i++) begin
         ic.up = ~ic.up;
         tick();
         chk("c_tog_count", 32'(ic.count), ic.up ? 0 : 15);
         chk("c_tog_wrap", 32'(ic.wrap), 1);
      end

      // Asynchronous reset mid-count.
      ia.load = 1; ia.load_val = 4'd5;
      tick();
      chk("a_pre_rst", 32'(ia.count), 5);
      ia.load = 0; ia.en = 1; ia.up = 1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_a_count", 32'(ia.count), 0);
      chk("async_b_sat", 32'(ib.sat), 0);
      chk("async_c_wrap", 32'(ic.wrap), 0);
      #2;
      reset_n = 1'b1;
      tick();
      chk("post_rst_a", 32'(ia.count), 1);
      ia.en = 0; ib.en = 0; ic.en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
